// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// against a mem_ready handshake, resolves branches, and tracks traps and retirement.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W = 4,
  parameter int MAX_WAIT   = 15,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr,
  input  logic                  eq,
  input  logic                  lt,
  input  logic                  ltu,
  input  logic                  mem_ready,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  pc_src,
  output logic                  reg_write,
  output logic                  alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [2:0]            imm_src,
  output logic [1:0]            result_src,
  output logic                  instr_done,
  output logic                  trap,
  output logic                  bus_err,
  output logic [CNT_W-1:0]      instret,
  output logic [3:0]            state_o
);

  // Memory handshake: a request (mem_read/mem_write) is held every cycle of its
  // state until mem_ready=1, which completes the access in that same cycle.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB       = 4'd7,
    BRANCH   = 4'd8,
    JAL      = 4'd9,
    TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  state_t              state, next_state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                trap_q, bus_err_q;
  logic [CNT_W-1:0]    instret_q;
  logic [3:0]          alu_op;
  logic                taken, timeout, waiting;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       unused_instr;
  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7_5     = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // alt selects SUB/SRA; immediate forms only honour it for the shift-right slot.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    case (funct3)
      3'b000:  taken = eq;
      3'b001:  taken = !eq;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  assign waiting = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign timeout = (MAX_WAIT != 0) && waiting && !mem_ready &&
                   (wait_cnt == WAIT_W'(MAX_WAIT));

  always_comb begin
    next_state = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;
    imm_src    = 3'd0;
    result_src = 2'd0;
    instr_done = 1'b0;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        case (opcode)
          OP_IMM:             next_state = EXEC_I;
          OP_REG:             next_state = EXEC_R;
          OP_LOAD, OP_STORE:  next_state = MEM_ADDR;
          OP_BRANCH:          next_state = BRANCH;
          OP_JAL:             next_state = JAL;
          OP_LUI:             next_state = WB;
          default:            next_state = TRAP;
        endcase
      end
      EXEC_I: begin
        alu_src_b  = 1'b1;
        alu_op     = alu_decode(funct3, funct7_5 && (funct3 == 3'b101));
        next_state = WB;
      end
      EXEC_R: begin
        alu_op     = alu_decode(funct3, funct7_5);
        next_state = WB;
      end
      MEM_ADDR: begin
        alu_src_b = 1'b1;
        if (opcode == OP_STORE) begin
          imm_src    = 3'd1;
          next_state = MEM_WR;
        end else begin
          next_state = MEM_RD;
        end
      end
      MEM_RD: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
        if (mem_ready) next_state = WB;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          next_state = FETCH;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = FETCH;
        if (opcode == OP_LOAD) begin
          result_src = 2'd1;
        end else if (opcode == OP_LUI) begin
          result_src = 2'd3;
          imm_src    = 3'd4;
        end
      end
      BRANCH: begin
        imm_src = 3'd2;
        alu_op  = ALU_SUB;
        if (funct3 == 3'b010 || funct3 == 3'b011) begin
          next_state = TRAP;
        end else begin
          instr_done = 1'b1;
          pc_write   = taken;
          pc_src     = taken;
          next_state = FETCH;
        end
      end
      JAL: begin
        reg_write  = 1'b1;
        result_src = 2'd2;
        pc_write   = 1'b1;
        pc_src     = 1'b1;
        imm_src    = 3'd3;
        instr_done = 1'b1;
        next_state = FETCH;
      end
      TRAP:    next_state = TRAP;
      default: next_state = FETCH;
    endcase
    if (timeout) next_state = TRAP;
    // Reset silences every strobe in the same cycle it is asserted.
    if (rst) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      alu_src_b  = 1'b0;
      alu_op     = ALU_ADD;
      imm_src    = 3'd0;
      result_src = 2'd0;
      instr_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      wait_cnt  <= '0;
      trap_q    <= 1'b0;
      bus_err_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) wait_cnt <= '0;
      else if (waiting && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
      if (next_state == TRAP && state != TRAP) begin
        trap_q    <= 1'b1;
        bus_err_q <= timeout;
      end
      if (instr_done) instret_q <= instret_q + 1'b1;
    end
  end

  assign alu_ctrl = ALU_CTRL_W'(alu_op);
  assign trap     = trap_q & ~rst;
  assign bus_err  = bus_err_q & ~rst;
  assign instret  = rst ? '0 : instret_q;
  assign state_o  = state;

endmodule
